// File: rtl/axi_id_compactor.sv
// axi_id_compactor: maps wide upstream AXI IDs onto a small pool of table
// indices, strips a colour field out of the request address, and restores the
// original ID on the response path.
// Optional feature: define AXI_ID_COMPACTOR_SAME_ID_ORDER_EN to stall a request
// whose ID is already outstanding, which keeps same-ID responses in order.
module axi_id_compactor #(
  parameter int ID_IN_W  = 16,
  parameter int ID_OUT_W = 4,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 40,
  parameter int BANK_BIT = 35,
  parameter int CUT_HI   = 15,
  parameter int CUT_LO   = 14
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_areset,
  input  logic [ID_IN_W-1:0]         s_id,
  input  logic [ADDR_W-1:0]          s_addr,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [ID_OUT_W-1:0]        m_id,
  output logic [ADDR_W-1:0]          m_addr,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic [ID_OUT_W-1:0]        m_rsp_id,
  input  logic                       m_rsp_last,
  input  logic                       m_rsp_valid,
  output logic                       m_rsp_ready,
  output logic [ID_IN_W-1:0]         s_rsp_id,
  output logic                       s_rsp_last,
  output logic                       s_rsp_valid,
  input  logic                       s_rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_unknown_id
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]   valid_q;
  logic [ID_IN_W-1:0] id_q [DEPTH];
  logic [ID_OUT_W-1:0] alloc_idx;
  logic               full;
  logic               stall_same;
  logic               rsp_known;
  logic [ID_IN_W-1:0] rsp_id_sel;
  logic               do_alloc;
  logic               rsp_hs;
  logic               do_free;
  logic [BANK_BIT-1:0] low_in;
  logic [BANK_BIT-1:0] lo_mask;
  logic               unused_addr_hi;

  assign full = (occupancy == OCC_W'(DEPTH));

  // Lowest free entry; scanning downward lets the lowest index win.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = ID_OUT_W'(i);
    end
  end

`ifdef AXI_ID_COMPACTOR_SAME_ID_ORDER_EN
  // Hold a request while any outstanding entry carries the same upstream ID.
  always_comb begin
    stall_same = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (id_q[i] == s_id)) stall_same = 1'b1;
    end
  end
`else
  assign stall_same = 1'b0;
`endif

  // Reset also masks the handshake so nothing is accepted while it is held.
  assign s_ready  = m_ready & ~full & ~stall_same & ~s00_axi_areset;
  assign m_valid  = s_valid & ~full & ~stall_same & ~s00_axi_areset;
  assign m_id     = alloc_idx;
  assign do_alloc = s_valid & s_ready;

  // Address: keep the bank bit, drop the colour field and close the gap.
  assign low_in         = s_addr[BANK_BIT-1:0];
  assign lo_mask        = (BANK_BIT'(1) << CUT_LO) - BANK_BIT'(1);
  assign unused_addr_hi = ^s_addr;

  // Build m_addr with everything above the bank bit forced to zero.
  always_comb begin
    m_addr = '0;
    m_addr[BANK_BIT] = s_addr[BANK_BIT];
    m_addr[BANK_BIT-1:0] = (low_in & lo_mask) | ((low_in >> (CUT_HI+1)) << CUT_LO);
  end

  // Response lookup; out-of-range or free entries report ID 0.
  always_comb begin
    rsp_known  = 1'b0;
    rsp_id_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((m_rsp_id == ID_OUT_W'(i)) && valid_q[i]) begin
        rsp_known  = 1'b1;
        rsp_id_sel = id_q[i];
      end
    end
  end

  assign s_rsp_valid = m_rsp_valid;
  assign m_rsp_ready = s_rsp_ready;
  assign s_rsp_last  = m_rsp_last;
  assign s_rsp_id    = rsp_id_sel;
  assign rsp_hs      = m_rsp_valid & s_rsp_ready;
  assign do_free     = rsp_hs & m_rsp_last & rsp_known;

  // Table update: the freed entry was valid, so it can never be the one allocated.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_free && (m_rsp_id == ID_OUT_W'(i))) valid_q[i] <= 1'b0;
        if (do_alloc && (alloc_idx == ID_OUT_W'(i))) begin
          valid_q[i] <= 1'b1;
          id_q[i]    <= s_id;
        end
      end
    end
  end

  // Occupancy tracks alloc/free; both or neither leaves it unchanged.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      occupancy <= '0;
    end else if (do_alloc && !do_free) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (do_free && !do_alloc) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

  // Sticky error on any response beat aimed at a free or nonexistent entry.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      err_unknown_id <= 1'b0;
    end else if (rsp_hs && !rsp_known) begin
      err_unknown_id <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_id_compactor.sv
module tb_axi_id_compactor;

  logic        s00_axi_aclk = 1'b0;
  logic        s00_axi_areset = 1'b0;
  logic [15:0] s_id = '0;
  logic [39:0] s_addr = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  m_id;
  logic [39:0] m_addr;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_rsp_id = '0;
  logic        m_rsp_last = 1'b0;
  logic        m_rsp_valid = 1'b0;
  logic        m_rsp_ready;
  logic [15:0] s_rsp_id;
  logic        s_rsp_last;
  logic        s_rsp_valid;
  logic        s_rsp_ready = 1'b0;
  logic [4:0]  occupancy;
  logic        err_unknown_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding set indexed by compacted ID.
  bit          mdl_valid [16];
  logic [15:0] mdl_id    [16];
  bit          mdl_err;

  axi_id_compactor dut (
    .s00_axi_aclk  (s00_axi_aclk),
    .s00_axi_areset(s00_axi_areset),
    .s_id          (s_id),
    .s_addr        (s_addr),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_id          (m_id),
    .m_addr        (m_addr),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_rsp_id      (m_rsp_id),
    .m_rsp_last    (m_rsp_last),
    .m_rsp_valid   (m_rsp_valid),
    .m_rsp_ready   (m_rsp_ready),
    .s_rsp_id      (s_rsp_id),
    .s_rsp_last    (s_rsp_last),
    .s_rsp_valid   (s_rsp_valid),
    .s_rsp_ready   (s_rsp_ready),
    .occupancy     (occupancy),
    .err_unknown_id(err_unknown_id)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mdl_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += mdl_valid[i] ? 1 : 0;
    return c;
  endfunction

  // Bank bit 35 kept, bits 15:14 dropped, bits 34:16 slide down to 32:14.
  function automatic logic [39:0] mdl_addr(input logic [39:0] a);
    logic [63:0] x, bank, mid, lo;
    x    = 64'(a);
    bank = (x >> 35) & 64'd1;
    mid  = (x >> 16) % (64'd1 << 19);
    lo   = x % (64'd1 << 14);
    return 40'((bank << 35) + (mid << 14) + lo);
  endfunction

  task automatic do_reset();
    s00_axi_areset = 1'b1;
    s_valid = 1'b0; m_ready = 1'b1; m_rsp_valid = 1'b0; s_rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_id[i] = '0;
    end
    mdl_err = 1'b0;
    #2;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_m_id", m_id, 0);
    check_val("rst_occupancy", occupancy, 0);
    check_val("rst_err", err_unknown_id, 0);
    @(posedge s00_axi_aclk); #1;
    s00_axi_areset = 1'b0;
  endtask

  // One clock: drive, check combinational outputs, clock, update model, check state.
  task automatic step(input bit sv, input logic [15:0] sid, input logic [39:0] sa, input bit mr,
                      input bit rv, input logic [3:0] rid, input bit rl, input bit rr);
    bit full, stall, known, exp_sr;
    int idx;
    s_valid = sv; s_id = sid; s_addr = sa; m_ready = mr;
    m_rsp_valid = rv; m_rsp_id = rid; m_rsp_last = rl; s_rsp_ready = rr;
    #2;
    full  = (mdl_count() == 16);
    stall = 1'b0;
`ifdef AXI_ID_COMPACTOR_SAME_ID_ORDER_EN
    for (int i = 0; i < 16; i++) if (mdl_valid[i] && mdl_id[i] == sid) stall = 1'b1;
`endif
    exp_sr = mr && !full && !stall;
    idx = 0;
    for (int i = 15; i >= 0; i--) if (!mdl_valid[i]) idx = i;
    known = mdl_valid[rid];
    check_val("s_ready", s_ready, exp_sr);
    check_val("m_valid", m_valid, sv && !full && !stall);
    if (!full) check_val("m_id", m_id, idx);
    check_val("m_addr", m_addr, mdl_addr(sa));
    check_val("s_rsp_valid", s_rsp_valid, rv);
    check_val("m_rsp_ready", m_rsp_ready, rr);
    check_val("s_rsp_last", s_rsp_last, rl);
    if (rv) check_val("s_rsp_id", s_rsp_id, known ? mdl_id[rid] : 16'h0);
    @(posedge s00_axi_aclk);
    if (sv && exp_sr) begin
      mdl_valid[idx] = 1'b1;
      mdl_id[idx] = sid;
    end
    if (rv && rr) begin
      if (known) begin
        if (rl) mdl_valid[rid] = 1'b0;
      end else begin
        mdl_err = 1'b1;
      end
    end
    #1;
    check_val("occupancy", occupancy, mdl_count());
    check_val("err_unknown_id", err_unknown_id, mdl_err);
  endtask

  initial begin
    do_reset();

    // Address mapping without a handshake.
    step(1, 16'h0001, 40'h8_0000_C123, 0, 0, 0, 0, 0);
    s_addr = 40'h8_0000_C123; #1;
    check_val("addr_example", m_addr, 40'h8_0000_0123);

    // Fill the table.
    for (int i = 0; i < 16; i++) step(1, 16'h100 + 16'(i), 40'(i) << 12, 1, 0, 0, 0, 0);
    check_val("fill_occ", occupancy, 16);
    step(1, 16'h1FF, 40'h0, 1, 0, 0, 0, 0);

    // Free 5 while full: not accepted this cycle, accepted as m_id 5 next cycle.
    step(1, 16'h200, 40'h0, 1, 1, 4'd5, 1, 1);
    step(1, 16'h200, 40'h0, 1, 0, 0, 0, 0);
    check_val("refill_occ", occupancy, 16);
    // Non-last beat leaves the entry allocated.
    step(0, 16'h0, 40'h0, 1, 1, 4'd3, 0, 1);

    // Simultaneous alloc and free.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'h10 + 16'(i), 40'h0, 1, 0, 0, 0, 0);
    step(1, 16'h13, 40'h0, 1, 1, 4'd1, 1, 1);
    check_val("simul_occ", occupancy, 3);
    step(1, 16'h14, 40'h0, 1, 0, 0, 0, 0);

    // Unknown ID response, sticky until reset.
    do_reset();
    step(0, 16'h0, 40'h0, 1, 1, 4'd7, 1, 1);
    step(0, 16'h0, 40'h0, 1, 0, 0, 0, 0);
    check_val("err_sticky", err_unknown_id, 1);
    do_reset();

    // Same ID while outstanding.
    step(1, 16'h42, 40'h0, 1, 0, 0, 0, 0);
    step(1, 16'h42, 40'h0, 1, 0, 0, 0, 0);
    step(1, 16'h42, 40'h0, 1, 1, 4'd0, 1, 1);
    step(1, 16'h42, 40'h0, 1, 0, 0, 0, 0);

    // Randomized traffic with a small ID pool to exercise collisions.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      step(bit'($urandom_range(0, 1)),
           16'h40 + 16'($urandom_range(0, 7)),
           {$urandom(), $urandom()} ,
           $urandom_range(0, 3) != 0,
           bit'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) != 0);
    end

    // Reset mid-operation discards outstanding entries.
    step(1, 16'h77, 40'h0, 1, 0, 0, 0, 0);
    do_reset();
    step(0, 16'h0, 40'h0, 1, 1, 4'd0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
